// File: rtl/double_tokens_pkg.sv
// Shared types and constants for the token doubling stage.
package token_pkg;

   // Backlog FSM: idle exactly when nothing is owed downstream.
   typedef enum logic {
      st_idle = 1'b0,
      st_busy = 1'b1
   } token_state_t;

   // Default backlog counter width; maximum backlog is 2^W - 1.
   localparam int TOKEN_CNT_W = 4;

endpackage : token_pkg

// File: rtl/double_tokens_counter.sv
// Saturating up/down counter holding the owed-token backlog.
// clr beats inc, inc beats dec; inc at max holds and pulses sat_hit.
module sat_updown_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         at_max,
   output logic         at_zero,
   output logic         sat_hit
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign cnt     = cnt_q;
   assign at_max  = &cnt_q;
   assign at_zero = (cnt_q == '0);
   // A lost increment: asked to grow while already full and not being cleared.
   assign sat_hit = inc & at_max & ~clr;

   // Next count: never wraps in either direction.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         if (!at_max) cnt_d = cnt_q + W'(1);
      end else if (dec) begin
         if (!at_zero) cnt_d = cnt_q - W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule : sat_updown_counter

// File: rtl/double_tokens.sv
// Serial token expander: each input token produces two output tokens.
// The first goes out combinationally in the same cycle; the second is
// queued in a saturating backlog and paid out one per cycle.
import token_pkg::*;

module double_tokens #(
   parameter int CNT_W = TOKEN_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic flush,
   output logic b,
   output logic busy,
   output logic overflow
);

   logic [CNT_W-1:0] pending;
   logic             at_max;
   logic             at_zero;
   logic             sat_hit;
   logic             inc;
   logic             dec;
   logic             unused_at_max;

   token_state_t     state_q;
   token_state_t     state_d;
   logic             overflow_q;
   logic             overflow_d;

   // An accepted token owes two and pays one now: net +1. An idle cycle
   // with backlog pays one: net -1. Flush drops everything including a.
   assign inc = a & ~flush;
   assign dec = ~a & ~flush & ~at_zero;

   sat_updown_counter #(
      .W (CNT_W)
   ) u_backlog (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc),
      .dec     (dec),
      .clr     (flush),
      .cnt     (pending),
      .at_max  (at_max),
      .at_zero (at_zero),
      .sat_hit (sat_hit)
   );

   // Saturation is reported through sat_hit; the level itself is not needed here.
   assign unused_at_max = at_max;

   // rst gates b directly so the stream drops without waiting for an edge.
   assign b        = ~rst & ~flush & (a | ~at_zero);
   assign busy     = ~at_zero;
   assign overflow = overflow_q;

   // Next state tracks whether the backlog will be nonzero after this edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         st_idle: begin
            if (a && !flush) state_d = st_busy;
         end
         st_busy: begin
            if (flush)                                state_d = st_idle;
            else if (!a && pending == CNT_W'(1))      state_d = st_idle;
         end
         default: state_d = st_idle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= st_idle;
      else     state_q <= state_d;
   end

   // Sticky loss flag; only reset clears it, flush leaves it alone.
   always_comb begin
      overflow_d = overflow_q | sat_hit;
   end

   // Overflow register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

endmodule : double_tokens

// File: tb/tb_double_tokens.sv
// Directed and random checks for double_tokens with CNT_W = 4.
module tb_double_tokens;
   import token_pkg::*;

   localparam int CW   = 4;
   localparam int PMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   logic a;
   logic flush;
   logic b;
   logic busy;
   logic overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int pmax  = 0;

   always #5 clk = ~clk;

   double_tokens #(.CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .flush    (flush),
      .b        (b),
      .busy     (busy),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // One cycle: inputs applied just after an edge, outputs sampled at negedge.
   task automatic step(input logic ai, input logic fi, output logic bo, output logic bz);
      a     = ai;
      flush = fi;
      @(negedge clk);
      bo = b;
      bz = busy;
      chk("state_vs_busy", 32'(dut.state_q == st_busy), 32'(busy));
      if (int'(dut.pending) > pmax) pmax = int'(dut.pending);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        bb, bz;
      logic [14:0] pa, ob, oz;
      int          ones, first_low, gap, m_pend, m_lost, na, nb, k;
      logic [2:0]  rv;

      // ---- reset state
      rst = 1'b1; a = 1'b1; flush = 1'b0;
      #12;
      chk("rst_b",        32'(b),            0);
      chk("rst_busy",     32'(busy),         0);
      chk("rst_overflow", 32'(overflow),     0);
      chk("rst_pending",  32'(dut.pending),  0);
      a   = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // ---- basic pattern
      pa = 15'b100_000_110_000_000;
      for (int i = 0; i < 15; i++) begin
         step(pa[14-i], 1'b0, bb, bz);
         ob[14-i] = bb;
         oz[14-i] = bz;
      end
      chk("basic_b",    32'(ob), 32'(15'b110_000_111_100_000));
      chk("basic_busy", 32'(oz), 32'(15'b010_000_011_100_000));

      // ---- 15-token burst: 30 contiguous outputs, no loss
      pmax = 0; ones = 0; first_low = -1; gap = 0;
      for (int i = 0; i < 45; i++) begin
         step(i < 15, 1'b0, bb, bz);
         if (bb) begin
            ones++;
            if (first_low >= 0) gap = 1;
         end else if (first_low < 0) begin
            first_low = i;
         end
      end
      chk("burst_ones",     32'(ones),      30);
      chk("burst_run_end",  32'(first_low), 30);
      chk("burst_gap",      32'(gap),       0);
      chk("burst_peak",     32'(pmax),      PMAX);
      chk("burst_overflow", 32'(overflow),  0);

      // ---- 17-token burst: two tokens lost, overflow on 16th edge
      pmax = 0; ones = 0;
      for (int i = 0; i < 45; i++) begin
         step(i < 17, 1'b0, bb, bz);
         if (bb) ones++;
         if (i == 14) chk("ovf_before16", 32'(overflow), 0);
         if (i == 15) chk("ovf_after16",  32'(overflow), 1);
      end
      chk("ovf_ones",   32'(ones),     32);
      chk("ovf_peak",   32'(pmax),     PMAX);
      chk("ovf_sticky", 32'(overflow), 1);
      chk("ovf_idle",   32'(busy),     0);

      // ---- flush with a token in the same cycle
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, bb, bz);
      chk("flush_pre_pend", 32'(dut.pending), 3);
      step(1'b1, 1'b1, bb, bz);
      chk("flush_b", 32'(bb), 0);
      chk("flush_pend", 32'(dut.pending), 0);
      ones = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, bb, bz);
         if (bb) ones++;
      end
      chk("flush_quiet",    32'(ones),     0);
      chk("flush_overflow", 32'(overflow), 1);

      // ---- async reset mid-backlog
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, bb, bz);
      chk("arst_pre_pend", 32'(dut.pending), 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_b",        32'(b),           0);
      chk("arst_busy",     32'(busy),        0);
      chk("arst_pend",     32'(dut.pending), 0);
      chk("arst_overflow", 32'(overflow),    0);
      #1 rst = 1'b0; a = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, bb, bz); rv[2] = bb;
      step(1'b0, 1'b0, bb, bz); rv[1] = bb;
      step(1'b0, 1'b0, bb, bz); rv[0] = bb;
      chk("arst_after_b", 32'(rv), 32'(3'b110));

      // ---- random regression against a small backlog model
      m_pend = 0; m_lost = 0; na = 0; nb = 0;
      for (int i = 0; i < 10000; i++) begin
         logic ai;
         ai = ($urandom_range(0, 99) < 40);
         step(ai, 1'b0, bb, bz);
         chk("rnd_b", 32'(bb), 32'(ai || (m_pend != 0)));
         if (ai) begin
            na++;
            if (m_pend == PMAX) m_lost++;
            else                m_pend++;
         end else if (m_pend > 0) begin
            m_pend--;
         end
         if (bb) nb++;
      end
      k = 0;
      while (busy && k < 64) begin
         step(1'b0, 1'b0, bb, bz);
         if (bb) nb++;
         k++;
      end
      chk("rnd_drained",  32'(busy),     0);
      chk("rnd_total",    32'(nb),       32'(2 * na - m_lost));
      chk("rnd_overflow", 32'(overflow), 32'(m_lost != 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_double_tokens
